servo_ramp_scheduler: RTL and testbench

SERVO_RAMP_SCHEDULER -- requirements
Module: servo_ramp_scheduler

---
 rtl/servo_ramp_scheduler_pkg.sv | 50 +++++
 rtl/servo_ramp_scheduler_step_calc.sv | 40 ++++
 rtl/servo_ramp_scheduler.sv | 143 ++++++++++++++
 tb/tb_servo_ramp_scheduler.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_ramp_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// servo_ramp_scheduler_pkg
// Shared constants and types for the servo ramp scheduler.
//   ANG_HOME        : angle every servo starts from after reset
//   ANG_MIN/ANG_MAX : accepted-target clamp window. SERVO_SOFT_LIMIT_EN
//                     selects the narrow window (10..170); without it the
//                     full 0..180 range applies.
//   NUM_SERVOS      : number of ramped channels
//   state_e         : scheduler FSM states
//   clamp_ang()     : folds a requested angle into [ANG_MIN, ANG_MAX]
// Build macro: SERVO_SOFT_LIMIT_EN
// ---------------------------------------------------------------------------
package servo_ramp_scheduler_pkg;

  localparam int         NUM_SERVOS   = 4;
  localparam logic [7:0] ANG_HOME     = 8'd90;

  localparam logic [7:0] ANG_MIN_SOFT = 8'd10;
  localparam logic [7:0] ANG_MAX_SOFT = 8'd170;
  localparam logic [7:0] ANG_MIN_FULL = 8'd0;
  localparam logic [7:0] ANG_MAX_FULL = 8'd180;

`ifdef SERVO_SOFT_LIMIT_EN
  localparam logic [7:0] ANG_MIN = ANG_MIN_SOFT;
  localparam logic [7:0] ANG_MAX = ANG_MAX_SOFT;
`else
  localparam logic [7:0] ANG_MIN = ANG_MIN_FULL;
  localparam logic [7:0] ANG_MAX = ANG_MAX_FULL;
`endif

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    UPDATE = 2'd1,
    CHECK  = 2'd2
  } state_e;

  // Signed int compare keeps the lower bound meaningful even when it is 0.
  function automatic logic [7:0] clamp_ang(input logic [7:0] ang);
    int ang_int;
    ang_int = int'(ang);
    if (ang_int > int'(ANG_MAX)) begin
      return ANG_MAX;
    end else if (ang_int < int'(ANG_MIN)) begin
      return ANG_MIN;
    end else begin
      return ang;
    end
  endfunction

endpackage

// File: rtl/servo_ramp_scheduler_step_calc.sv
// ---------------------------------------------------------------------------
// servo_step_calc
// Combinational one-step ramp for a single servo: moves cur toward tgt by
// at most STEP_DEG degrees, never past tgt.
//   cur_i   : current commanded angle
//   tgt_i   : target angle
//   nxt_o   : angle after this step
//   moved_o : high when nxt_o differs from cur_i
// ---------------------------------------------------------------------------
module servo_step_calc #(
  parameter int STEP_DEG = 1
) (
  input  logic [7:0] cur_i,
  input  logic [7:0] tgt_i,
  output logic [7:0] nxt_o,
  output logic       moved_o
);

  // Any step wider than the 8-bit range behaves as "jump straight to target".
  localparam int         STEP_SAT = (STEP_DEG > 255) ? 255 : ((STEP_DEG < 0) ? 0 : STEP_DEG);
  localparam logic [7:0] STEP_W   = 8'(STEP_SAT);

  logic [7:0] diff_d;

  // The step is limited to the remaining distance, so the sum stays between
  // cur and tgt and can neither overshoot nor wrap.
  always_comb begin
    diff_d = 8'd0;
    nxt_o  = cur_i;
    if (cur_i < tgt_i) begin
      diff_d = tgt_i - cur_i;
      nxt_o  = cur_i + ((diff_d < STEP_W) ? diff_d : STEP_W);
    end else if (cur_i > tgt_i) begin
      diff_d = cur_i - tgt_i;
      nxt_o  = cur_i - ((diff_d < STEP_W) ? diff_d : STEP_W);
    end
    moved_o = (nxt_o != cur_i);
  end

endmodule

// File: rtl/servo_ramp_scheduler.sv
// ---------------------------------------------------------------------------
// servo_ramp_scheduler
// Ramps four servo angles toward software-written targets, one bounded step
// per servo every STEP_TICKS clocks.
//   clk, rst            : clock, synchronous active-high reset
//   tgt_valid/tgt_ready : target write handshake (ready low during UPDATE)
//   tgt_idx, tgt_ang    : servo select and requested angle (clamped on write)
//   ang_servo_1..4      : current commanded angles
//   busy                : some servo has not yet reached its target
//   done                : one-cycle pulse when a pass leaves every servo
//                         settled after at least one of them moved
// Parameters: STEP_TICKS (clocks spent in WAIT), STEP_DEG (max step).
// Build macro: SERVO_SOFT_LIMIT_EN narrows the clamp window (see package).
// ---------------------------------------------------------------------------
module servo_ramp_scheduler
  import servo_ramp_scheduler_pkg::*;
#(
  parameter int STEP_TICKS = 50000,
  parameter int STEP_DEG   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tgt_valid,
  output logic       tgt_ready,
  input  logic [1:0] tgt_idx,
  input  logic [7:0] tgt_ang,
  output logic [7:0] ang_servo_1,
  output logic [7:0] ang_servo_2,
  output logic [7:0] ang_servo_3,
  output logic [7:0] ang_servo_4,
  output logic       busy,
  output logic       done
);

  localparam int                TICK_W    = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(STEP_TICKS - 1);
  localparam logic [1:0]        IDX_LAST  = 2'(NUM_SERVOS - 1);

  state_e            state_q;
  logic [TICK_W-1:0] tick_q;
  logic [1:0]        idx_q;
  logic              moved_q;
  logic              done_q;
  logic              ready_q;
  logic [7:0]        cur_q [NUM_SERVOS];
  logic [7:0]        tgt_q [NUM_SERVOS];

  logic [7:0]            step_nxt;
  logic                  step_moved;
  logic [7:0]            tgt_ang_d;
  logic                  accept;
  logic [NUM_SERVOS-1:0] differs;
  logic [NUM_SERVOS-1:0] settled_after;

  servo_step_calc #(
    .STEP_DEG (STEP_DEG)
  ) u_step (
    .cur_i   (cur_q[idx_q]),
    .tgt_i   (tgt_q[idx_q]),
    .nxt_o   (step_nxt),
    .moved_o (step_moved)
  );

  assign tgt_ang_d = clamp_ang(tgt_ang);
  assign accept    = tgt_valid && ready_q;

  // settled_after looks at the servo being stepped this cycle through its
  // post-step value, so the last UPDATE cycle can decide done without an
  // extra compare cycle.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SERVOS; gi++) begin : g_cmp
      assign differs[gi]       = (cur_q[gi] != tgt_q[gi]);
      assign settled_after[gi] = (idx_q == 2'(gi)) ? (step_nxt == tgt_q[gi])
                                                   : (cur_q[gi] == tgt_q[gi]);
    end
  endgenerate

  assign busy        = |differs;
  assign tgt_ready   = ready_q;
  assign done        = done_q;
  assign ang_servo_1 = cur_q[0];
  assign ang_servo_2 = cur_q[1];
  assign ang_servo_3 = cur_q[2];
  assign ang_servo_4 = cur_q[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT;
      tick_q  <= '0;
      idx_q   <= 2'd0;
      moved_q <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      for (int i = 0; i < NUM_SERVOS; i++) begin
        cur_q[i] <= ANG_HOME;
        tgt_q[i] <= ANG_HOME;
      end
    end else begin
      done_q <= 1'b0;

      // ready_q is low throughout UPDATE, so targets are frozen during a pass.
      if (accept) begin
        tgt_q[tgt_idx] <= tgt_ang_d;
      end

      case (state_q)
        WAIT: begin
          if (tick_q == TICK_LAST) begin
            tick_q  <= '0;
            idx_q   <= 2'd0;
            ready_q <= 1'b0;
            state_q <= UPDATE;
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end

        UPDATE: begin
          cur_q[idx_q] <= step_nxt;
          // First servo of the pass restarts the "something moved" flag.
          moved_q <= (idx_q == 2'd0) ? step_moved : (moved_q | step_moved);
          if (idx_q == IDX_LAST) begin
            done_q  <= (moved_q | step_moved) & (&settled_after);
            ready_q <= 1'b1;
            state_q <= CHECK;
          end else begin
            idx_q <= idx_q + 2'd1;
          end
        end

        CHECK: begin
          state_q <= WAIT;
        end

        default: begin
          state_q <= WAIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_servo_ramp_scheduler.sv
// ---------------------------------------------------------------------------
// tb_servo_ramp_scheduler
// Two schedulers (STEP_DEG 1 and 4, STEP_TICKS 4) share one stimulus stream.
// The reference model treats time as a 9-cycle period: 4 waiting cycles,
// 4 cycles stepping servos 0..3 in turn, 1 check cycle.
// Build macro: SERVO_SOFT_LIMIT_EN changes the expected clamp window.
// ---------------------------------------------------------------------------
module tb_servo_ramp_scheduler;

  localparam int TICKS  = 4;
  localparam int STEP_A = 1;
  localparam int STEP_B = 4;
  localparam int PERIOD = TICKS + 5;
`ifdef SERVO_SOFT_LIMIT_EN
  localparam int LIM_MIN = 10;
  localparam int LIM_MAX = 170;
`else
  localparam int LIM_MIN = 0;
  localparam int LIM_MAX = 180;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       tgt_valid;
  logic [1:0] tgt_idx;
  logic [7:0] tgt_ang;
  logic [7:0] ang_out  [2][4];
  logic       rdy_out  [2];
  logic       busy_out [2];
  logic       done_out [2];

  always #5 clk = ~clk;

  servo_ramp_scheduler #(.STEP_TICKS(TICKS), .STEP_DEG(STEP_A)) u_dut_a (
    .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_ready(rdy_out[0]),
    .tgt_idx(tgt_idx), .tgt_ang(tgt_ang),
    .ang_servo_1(ang_out[0][0]), .ang_servo_2(ang_out[0][1]),
    .ang_servo_3(ang_out[0][2]), .ang_servo_4(ang_out[0][3]),
    .busy(busy_out[0]), .done(done_out[0])
  );

  servo_ramp_scheduler #(.STEP_TICKS(TICKS), .STEP_DEG(STEP_B)) u_dut_b (
    .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_ready(rdy_out[1]),
    .tgt_idx(tgt_idx), .tgt_ang(tgt_ang),
    .ang_servo_1(ang_out[1][0]), .ang_servo_2(ang_out[1][1]),
    .ang_servo_3(ang_out[1][2]), .ang_servo_4(ang_out[1][3]),
    .busy(busy_out[1]), .done(done_out[1])
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  int mcur [2][4];
  int mtgt [4];
  int phase;
  int moved [2];
  int done_seen [2];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic int step_of(input int d);
    return (d == 0) ? STEP_A : STEP_B;
  endfunction

  function automatic int ramp(input int c, input int t, input int s);
    if (c < t) return c + ((t - c) < s ? (t - c) : s);
    if (c > t) return c - ((c - t) < s ? (c - t) : s);
    return c;
  endfunction

  function automatic int clamp(input int a);
    if (a > LIM_MAX) return LIM_MAX;
    if (a < LIM_MIN) return LIM_MIN;
    return a;
  endfunction

  function automatic bit all_settled(input int d);
    for (int s = 0; s < 4; s++) if (mcur[d][s] != mtgt[s]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit in_update();
    return (phase >= TICKS) && (phase < TICKS + 4);
  endfunction

  task automatic model_home();
    for (int s = 0; s < 4; s++) begin
      mtgt[s]    = 90;
      mcur[0][s] = 90;
      mcur[1][s] = 90;
    end
    phase    = 0;
    moved[0] = 0;
    moved[1] = 0;
  endtask

  // Per-cycle compare of every output of both DUTs against the model.
  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < 4; s++)
        check($sformatf("dut%0d ang_servo_%0d ph%0d", d, s + 1, phase), int'(ang_out[d][s]), mcur[d][s]);
      check($sformatf("dut%0d busy ph%0d", d, phase), int'(busy_out[d]), all_settled(d) ? 0 : 1);
      check($sformatf("dut%0d tgt_ready ph%0d", d, phase), int'(rdy_out[d]), in_update() ? 0 : 1);
      check($sformatf("dut%0d done ph%0d", d, phase), int'(done_out[d]),
            (phase == PERIOD - 1 && moved[d] != 0 && all_settled(d)) ? 1 : 0);
      if (done_out[d] === 1'b1) done_seen[d]++;
    end
  endtask

  // One clock: check, drive, advance model, land on the next falling edge.
  task automatic tick(input bit v, input int idx, input int ang, input bit r);
    int k;
    int nc;
    compare_all();
    tgt_valid = v;
    tgt_idx   = 2'(idx);
    tgt_ang   = 8'(ang);
    rst       = r;
    $display("cyc ph=%0d v=%0d idx=%0d ang=%0d rst=%0d", phase, v, idx, ang, r);
    if (r) begin
      model_home();
    end else begin
      if (in_update()) begin
        k = phase - TICKS;
        for (int d = 0; d < 2; d++) begin
          nc = ramp(mcur[d][k], mtgt[k], step_of(d));
          if (k == 0) moved[d] = 0;
          if (nc != mcur[d][k]) moved[d] = 1;
          mcur[d][k] = nc;
        end
      end else if (v) begin
        mtgt[idx] = clamp(ang);
      end
      phase = (phase + 1) % PERIOD;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    tick(1'b0, 0, 0, 1'b0);
  endtask

  // Advance until the model sits in the check cycle of the next pass.
  task automatic run_to_check();
    do idle(); while (phase != PERIOD - 1);
  endtask

  initial begin
    int d0;
    int d1;
    int lowc;
    int ang;

    rst       = 1'b1;
    tgt_valid = 1'b0;
    tgt_idx   = 2'd0;
    tgt_ang   = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_home();
    rst = 1'b0;

    // Reset release literals
    for (int s = 0; s < 4; s++) check($sformatf("reset ang_servo_%0d", s + 1), int'(ang_out[0][s]), 90);
    check("reset busy", int'(busy_out[0]), 0);
    check("reset done", int'(done_out[0]), 0);
    check("reset tgt_ready", int'(rdy_out[0]), 1);

    // Single move 90 -> 95
    d0 = done_seen[0];
    d1 = done_seen[1];
    tick(1'b1, 0, 95, 1'b0);
    for (int p = 0; p < 5; p++) begin
      run_to_check();
      check($sformatf("single move pass%0d step1", p + 1), int'(ang_out[0][0]), 91 + p);
      if (p == 0) check("single move pass1 step4", int'(ang_out[1][0]), 94);
      if (p == 4) check("single move done pulse", int'(done_out[0]), 1);
    end
    idle();
    check("single move done count step1", done_seen[0] - d0, 1);
    check("single move done count step4", done_seen[1] - d1, 1);
    check("single move busy fell", int'(busy_out[0]), 0);

    // No overshoot: write in check cycle, applied by the following pass
    while (phase != PERIOD - 1) idle();
    tick(1'b1, 1, 92, 1'b0);
    run_to_check();
    check("no overshoot step4", int'(ang_out[1][1]), 92);
    check("no overshoot step1", int'(ang_out[0][1]), 91);

    // Handshake held across UPDATE
    while (phase != TICKS) idle();
    lowc = 0;
    while (rdy_out[0] == 1'b0 && lowc < 20) begin
      tick(1'b1, 3, 100, 1'b0);
      lowc++;
    end
    check("handshake ready-low cycles", lowc, 4);
    tick(1'b1, 3, 100, 1'b0);
    run_to_check();
    check("handshake write landed", int'(ang_out[0][3]), 91);

    // Clamp of an out-of-range target
    tick(1'b1, 2, 200, 1'b0);
    for (int p = 0; p < 100; p++) run_to_check();
    check("clamp high step1", int'(ang_out[0][2]), LIM_MAX);
    check("clamp high step4", int'(ang_out[1][2]), LIM_MAX);
    check("clamp settled busy", int'(busy_out[0]), 0);

    // Reset during the second UPDATE cycle
    tick(1'b1, 0, 50, 1'b0);
    while (phase != TICKS + 1) idle();
    d0 = done_seen[0];
    d1 = done_seen[1];
    tick(1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 2 * PERIOD; i++) idle();
    for (int s = 0; s < 4; s++) check($sformatf("midreset ang_servo_%0d", s + 1), int'(ang_out[0][s]), 90);
    check("midreset no done step1", done_seen[0] - d0, 0);
    check("midreset no done step4", done_seen[1] - d1, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(1, 0) == 1) ang = int'($urandom_range(255, 0));
      else ang = int'($urandom_range(100, 80));
      tick(($urandom_range(9, 0) < 3), int'($urandom_range(3, 0)), ang,
           ($urandom_range(299, 0) == 0));
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
